// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mem_access_unit_pkg
//  Purpose : Shared types and helpers for the load/store front-end. It holds
//            the CPU op encoding, the FSM state encoding and the
//            classification helpers (store / misalignment).
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package mem_access_unit_pkg;

   // CPU request encoding as presented on the op port
   typedef enum logic [2:0] {
      op_lb  = 3'b000,
      op_lh  = 3'b001,
      op_lw  = 3'b010,
      op_lbu = 3'b011,
      op_lhu = 3'b100,
      op_sb  = 3'b101,
      op_sh  = 3'b110,
      op_sw  = 3'b111
   } op_t;

   typedef enum logic [1:0] {
      st_idle = 2'd0,
      st_rd   = 2'd1,
      st_cap  = 2'd2,
      st_wr   = 2'd3
   } state_t;

   function automatic logic is_store(input op_t op);
      return (op == op_sb) || (op == op_sh) || (op == op_sw);
   endfunction

   // Byte ops can never be misaligned; halves need an even offset and
   // words need offset 0.
   function automatic logic is_misaligned(input op_t op, input logic [1:0] off);
      logic r;
      r = 1'b0;
      case (op)
         op_lh, op_lhu, op_sh: r = off[0];
         op_lw, op_sw:         r = (off != 2'b00);
         default:              r = 1'b0;
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_lane_align.sv
`default_nettype none
// ============================================================================
//  Module  : mem_access_unit_lane_align
//  Purpose : Combinational lane steering for the load/store front-end, using
//            big-endian lane numbering (offset 0 = bits [31:24]).
//            - load path : pick byte/half from the word and sign/zero extend
//            - store path: replace the addressed byte/half with store data
//  Ports   : i_op    request op
//            i_off   byte offset within the word
//            i_word  word read from DataMemory
//            i_wdata store data (SB uses [7:0], SH uses [15:0])
//            o_load  extended load result
//            o_merge word with the addressed lane replaced
//  Rev     : 1.0  initial release
// ============================================================================
module mem_access_unit_lane_align
   import mem_access_unit_pkg::*;
(
   input  op_t         i_op,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_word,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_load,
   output logic [31:0] o_merge
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = 8'h00;
      case (i_off)
         2'd0:    w_byte = i_word[31:24];
         2'd1:    w_byte = i_word[23:16];
         2'd2:    w_byte = i_word[15:8];
         default: w_byte = i_word[7:0];
      endcase
      // offset bit 0 is guaranteed clear for half accesses
      w_half = i_off[1] ? i_word[15:0] : i_word[31:16];
   end

   always_comb begin
      o_load = i_word;
      case (i_op)
         op_lb:   o_load = {{24{w_byte[7]}}, w_byte};
         op_lbu:  o_load = {24'h000000, w_byte};
         op_lh:   o_load = {{16{w_half[15]}}, w_half};
         op_lhu:  o_load = {16'h0000, w_half};
         default: o_load = i_word;
      endcase
   end

   always_comb begin
      o_merge = i_word;
      case (i_op)
         op_sb: begin
            case (i_off)
               2'd0:    o_merge[31:24] = i_wdata[7:0];
               2'd1:    o_merge[23:16] = i_wdata[7:0];
               2'd2:    o_merge[15:8]  = i_wdata[7:0];
               default: o_merge[7:0]   = i_wdata[7:0];
            endcase
         end
         op_sh: begin
            if (i_off[1]) o_merge[15:0]  = i_wdata[15:0];
            else          o_merge[31:16] = i_wdata[15:0];
         end
         op_sw:   o_merge = i_wdata;
         default: o_merge = i_word;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module  : mem_access_unit
//  Purpose : CPU load/store front-end driving DataMemory. Converts one
//            LB/LBU/LH/LHU/LW/SB/SH/SW byte-addressed request into word
//            accesses; sub-word stores use read-modify-write. Misaligned
//            requests complete at once with err and never touch memory.
//  Ports   : clk, reset            clock / async active-high reset
//            req, op, addr, wdata  CPU request (sampled only when idle)
//            busy, done, err       status; done is a one-cycle pulse
//            rdata                 last completed load result
//            mem_addr, mem_din     DataMemory word address / write data
//            mem_wen, mem_ren      DataMemory strobes
//            mem_dout              DataMemory read data (1-cycle latency)
//  Rev     : 1.0  initial release
// ============================================================================
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic [2:0]        op,
   input  logic [ADDR_W+1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              mem_wen,
   output logic              mem_ren,
   input  logic [DATA_W-1:0] mem_dout
);

   state_t            r_state;
   state_t            w_state_nxt;
   op_t               r_op;
   logic [1:0]        r_off;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_merge;
   logic [DATA_W-1:0] r_rdata;
   logic [ADDR_W-1:0] r_mem_addr;
   logic              r_done;
   logic              r_err;

   op_t               w_op_in;
   logic              w_accept;
   logic              w_misalign;
   logic [DATA_W-1:0] w_load;
   logic [DATA_W-1:0] w_merge;

   assign w_op_in    = op_t'(op);
   assign w_misalign = is_misaligned(w_op_in, addr[1:0]);

   mem_access_unit_lane_align u_lane_align (
      .i_op    (r_op),
      .i_off   (r_off),
      .i_word  (mem_dout),
      .i_wdata (r_wdata),
      .o_load  (w_load),
      .o_merge (w_merge)
   );

   // Next-state and strobe decode. Strobes come from the registered state
   // only, so ren and wen can never overlap.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      busy        = (r_state != st_idle);
      mem_ren     = (r_state == st_rd);
      mem_wen     = (r_state == st_wr);
      case (r_state)
         st_idle: begin
            if (req) begin
               w_accept = 1'b1;
               if (w_misalign)             w_state_nxt = st_idle;
               else if (w_op_in == op_sw)  w_state_nxt = st_wr;
               else                        w_state_nxt = st_rd;
            end
         end
         st_rd:   w_state_nxt = st_cap;
         st_cap:  w_state_nxt = is_store(r_op) ? st_wr : st_idle;
         st_wr:   w_state_nxt = st_idle;
         default: w_state_nxt = st_idle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= st_idle;
         r_op       <= op_lb;
         r_off      <= 2'b00;
         r_wdata    <= '0;
         r_merge    <= '0;
         r_rdata    <= '0;
         r_mem_addr <= '0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         if (w_accept) begin
            r_op       <= w_op_in;
            r_off      <= addr[1:0];
            r_wdata    <= wdata;
            r_mem_addr <= addr[ADDR_W+1:2];
            if (w_misalign) begin
               r_done <= 1'b1;
               r_err  <= 1'b1;
            end
         end
         // mem_dout holds the word read during st_rd
         if (r_state == st_cap) begin
            if (is_store(r_op)) begin
               r_merge <= w_merge;
            end else begin
               r_rdata <= w_load;
               r_done  <= 1'b1;
            end
         end
         if (r_state == st_wr) r_done <= 1'b1;
      end
   end

   assign done     = r_done;
   assign err      = r_err;
   assign rdata    = r_rdata;
   assign mem_addr = r_mem_addr;
   // Full-word stores bypass the merge register entirely
   assign mem_din  = (r_op == op_sw) ? r_wdata : r_merge;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module  : tb_mem_access_unit
//  Purpose : Self-checking bench for mem_access_unit with a DataMemory
//            behind it, a word-array reference model and a scoreboard.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

   localparam int LB = 0, LH = 1, LW = 2, LBU = 3, LHU = 4, SB = 5, SH = 6, SW = 7;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [11:0] addr = 12'd0;
   logic [31:0] wdata = 32'd0;
   logic        busy, done, err;
   logic [31:0] rdata;
   logic [9:0]  mem_addr;
   logic [31:0] mem_din;
   logic        mem_wen, mem_ren;
   logic [31:0] mem_dout = 32'd0;

   always #5 clk = ~clk;

   mem_access_unit #(.ADDR_W(10), .DATA_W(32)) dut (
      .clk(clk), .reset(reset), .req(req), .op(op), .addr(addr), .wdata(wdata),
      .busy(busy), .done(done), .err(err), .rdata(rdata),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_wen(mem_wen), .mem_ren(mem_ren),
      .mem_dout(mem_dout)
   );

   // DataMemory: synchronous write, registered read
   logic [31:0] dmem [0:1023] = '{default: 32'd0};
   always @(posedge clk) begin
      if (mem_wen) dmem[mem_addr] <= mem_din;
      if (mem_ren) mem_dout <= dmem[mem_addr];
   end

   // Reference model state
   logic [31:0] ref_mem [0:1023] = '{default: 32'd0};
   logic [31:0] model_rdata = 32'd0;

   // lat = clock edges from the accepting edge to the edge raising done
   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          lat;
      int          nren;
      int          nwen;
      logic [9:0]  word;
      logic [31:0] wword;
      int          acc;
   } exp_t;
   exp_t sb[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
      end
   endtask

   function automatic logic [31:0] model_load(input int o, input logic [31:0] w, input int off);
      logic [31:0] b;
      int v;
      b = 32'd0;
      v = 0;
      case (o)
         LB, LBU: begin
            b = (w >> (24 - 8 * off)) & 32'hFF;
            v = int'(b);
            if (o == LB && v >= 128) v = v - 256;
         end
         LH, LHU: begin
            b = (w >> (16 - 8 * off)) & 32'hFFFF;
            v = int'(b);
            if (o == LH && v >= 32768) v = v - 65536;
         end
         default: v = int'(w);
      endcase
      return 32'(v);
   endfunction

   function automatic logic [31:0] model_store(input int o, input logic [31:0] w,
                                               input int off, input logic [31:0] d);
      logic [31:0] mask;
      int          sh;
      if (o == SW) return d;
      sh   = (o == SB) ? 24 - 8 * off : 16 - 8 * off;
      mask = ((o == SB) ? 32'hFF : 32'hFFFF) << sh;
      return (w & ~mask) | ((d << sh) & mask);
   endfunction

   // Driver: waits for idle, presents one request, pushes its expectation.
   // hold keeps req asserted (with a different payload) for extra cycles
   // while the unit is busy; those must be ignored.
   task automatic issue(input int o, input logic [11:0] a, input logic [31:0] d, input int hold);
      int   waited;
      int   off;
      int   w;
      logic mis;
      exp_t e;
      waited = 0;
      while (busy !== 1'b0 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 50) chk("idle_wait_timeout", 32'd1, 32'd0);
      off = int'(a[1:0]);
      w   = int'(a[11:2]);
      mis = ((o == LH || o == LHU || o == SH) && a[0]) || ((o == LW || o == SW) && off != 0);
      e.err = mis; e.lat = 0; e.nren = 0; e.nwen = 0;
      e.word = a[11:2]; e.wword = 32'd0; e.acc = cyc + 1;
      if (!mis) begin
         if (o <= LHU) begin
            model_rdata = model_load(o, ref_mem[w], off);
            e.nren = 1; e.lat = 2;
         end else begin
            ref_mem[w] = model_store(o, ref_mem[w], off, d);
            e.wword = ref_mem[w];
            e.nwen = 1;
            e.nren = (o == SW) ? 0 : 1;
            e.lat  = (o == SW) ? 1 : 3;
         end
      end
      e.rdata = model_rdata;
      sb.push_back(e);
      req = 1'b1; op = 3'(o); addr = a; wdata = d;
      @(negedge clk);
      if (mis) hold = 0;
      for (int i = 0; i < hold; i++) begin
         op = 3'(SW); addr = 12'h3FC; wdata = 32'hDEADDEAD;
         @(negedge clk);
      end
      req = 1'b0;
   endtask

   // Monitor: counts strobes and pops the scoreboard on every done pulse
   int          ren_cnt = 0, wen_cnt = 0;
   logic [9:0]  ren_a = 10'd0, wen_a = 10'd0;
   logic [31:0] wen_d = 32'd0;
   exp_t        m;
   always @(negedge clk) begin
      if (reset) begin
         ren_cnt = 0;
         wen_cnt = 0;
         chk("reset_outputs", {busy, done, err, mem_wen, mem_ren, 27'd0} | rdata | mem_din
             | {22'd0, mem_addr}, 32'd0);
      end else begin
         if (mem_ren && mem_wen) chk("ren_wen_overlap", 32'd1, 32'd0);
         if (mem_ren) begin ren_cnt++; ren_a = mem_addr; end
         if (mem_wen) begin wen_cnt++; wen_a = mem_addr; wen_d = mem_din; end
         if (done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               m = sb.pop_front();
               chk("err", {31'd0, err}, {31'd0, m.err});
               chk("rdata", rdata, m.rdata);
               chk("latency", 32'(cyc - m.acc), 32'(m.lat));
               chk("ren_cycles", 32'(ren_cnt), 32'(m.nren));
               chk("wen_cycles", 32'(wen_cnt), 32'(m.nwen));
               if (m.nren != 0) chk("ren_addr", {22'd0, ren_a}, {22'd0, m.word});
               if (m.nwen != 0) begin
                  chk("wen_addr", {22'd0, wen_a}, {22'd0, m.word});
                  chk("wen_data", wen_d, m.wword);
               end
            end
            ren_cnt = 0;
            wen_cnt = 0;
         end
      end
   end

   initial begin
      int o, ws, off, waited;
      logic [9:0] wd;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // basic store then load-back, lane extraction on 0xCAFEBABE
      issue(SW,  12'h03C, 32'hCAFEBABE, 0);
      issue(LW,  12'h03C, 32'h0, 0);
      issue(LB,  12'h03D, 32'h0, 0);
      issue(LBU, 12'h03D, 32'h0, 0);
      issue(LH,  12'h03E, 32'h0, 0);
      issue(LHU, 12'h03E, 32'h0, 0);
      // read-modify-write sub-word stores
      issue(SB,  12'h03F, 32'h00000011, 0);
      issue(SH,  12'h03C, 32'h00001234, 0);
      issue(LW,  12'h03C, 32'h0, 0);
      // misaligned requests
      issue(LW,  12'h191, 32'h0, 0);
      issue(SH,  12'h065, 32'hFFFF, 0);
      // req held through a load, then back-to-back requests in done cycles
      issue(LW,  12'h03C, 32'h0, 2);
      issue(LBU, 12'h03C, 32'h0, 0);
      issue(SW,  12'hFFC, 32'h0BADF00D, 0);
      issue(LH,  12'hFFE, 32'h0, 0);

      // reset while an SB sits in CAP must abandon the write
      issue(SW, 12'h190, 32'h12345678, 0);
      waited = 0;
      while ((busy !== 1'b0 || sb.size() != 0) && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 50) chk("pre_reset_idle_timeout", 32'd1, 32'd0);
      req = 1'b1; op = 3'(SB); addr = 12'h190; wdata = 32'h55;
      @(posedge clk);           // accepted, enters RD
      #1 req = 1'b0;
      @(posedge clk);           // enters CAP
      #2 reset = 1'b1;
      model_rdata = 32'd0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      issue(LW, 12'h192, 32'h0, 0);   // misaligned: rdata must still be 0
      issue(LW, 12'h190, 32'h0, 0);   // word must be unmodified

      // randomized traffic over a low window and the top of memory
      for (int n = 0; n < 250; n++) begin
         o   = int'($urandom_range(0, 7));
         ws  = int'($urandom_range(0, 19));
         wd  = (ws < 16) ? 10'(ws) : 10'(1004 + ws);
         off = int'($urandom_range(0, 3));
         issue(o, {wd, 2'(off)}, $urandom, ($urandom_range(0, 3) == 0) ? 1 : 0);
      end

      waited = 0;
      while (sb.size() != 0 && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
